// File: rtl/seven_segment_scan_n.sv
// Signed WIDTH-bit value to multiplexed DIGITS-digit common-anode display.
// A serial double-dabble engine converts the magnitude to BCD. The display
// registers update only when a conversion commits. The scan inserts one
// dead cycle at the start of every digit slot.
module seven_segment_scan_n #(
  parameter int WIDTH         = 8,
  parameter int DIGITS        = 4,
  parameter int REFRESH_BITS  = 18,
  parameter int BLANK_LEADING = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic              overflow,
  output logic [DIGITS-1:0] anode_n,
  output logic [6:0]        seg_n
);

  // Number of BCD nibbles: ceil((WIDTH+1)*log10(2)), and never fewer than DIGITS.
  function automatic int bcd_nibbles(input int w, input int d);
    int n;
    n = ((w + 1) * 30103 + 99999) / 100000;
    return (n < d) ? d : n;
  endfunction

  localparam int NIB = bcd_nibbles(WIDTH, DIGITS);
  localparam int CW  = $clog2(WIDTH);
  localparam int IW  = $clog2(DIGITS);

  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return GLYPH_BLANK;
    endcase
  endfunction

  state_t              state_q;
  logic [WIDTH-1:0]    bin_q;
  logic [4*NIB-1:0]    bcd_q;
  logic                neg_q;
  logic [CW-1:0]       cnt_q;
  logic                busy_q;
  logic [4*DIGITS-1:0] disp_bcd_q, disp_bcd_d;
  logic                disp_neg_q, disp_neg_d;
  logic                disp_ovf_q, disp_ovf_d;
  logic [REFRESH_BITS-1:0] pre_q, pre_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   anode_n_q, anode_n_d;
  logic [6:0]          seg_n_q, seg_n_d;

  logic [WIDTH-1:0]    mag;
  logic [4*NIB-1:0]    bcd_adj, bcd_step;
  logic                ovf_now;
  logic [IW-1:0]       msd;
  logic [6:0]          glyph;

  // Magnitude of the most negative value is 2^(WIDTH-1), which still fits WIDTH unsigned bits.
  always_comb begin
    mag = value[WIDTH-1] ? -value : value;
  end

  // One double-dabble step: add-3 correction on each nibble, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_step = (bcd_adj << 1) | (4*NIB)'(bin_q[WIDTH-1]);
    ovf_now  = |bcd_q[4*NIB-1 : 4*(DIGITS-1)];
  end

  // Display registers take the conversion result only on the commit cycle.
  always_comb begin
    disp_bcd_d = disp_bcd_q;
    disp_neg_d = disp_neg_q;
    disp_ovf_d = disp_ovf_q;
    if (state_q == COMMIT) begin
      disp_bcd_d = bcd_q[4*DIGITS-1:0];
      disp_neg_d = neg_q;
      disp_ovf_d = ovf_now;
    end
  end

  // Conversion FSM: capture on load, WIDTH shift cycles, one commit cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
      disp_ovf_q <= 1'b0;
    end else begin
      disp_bcd_q <= disp_bcd_d;
      disp_neg_q <= disp_neg_d;
      disp_ovf_q <= disp_ovf_d;
      case (state_q)
        IDLE: begin
          if (load) begin
            bin_q   <= mag;
            bcd_q   <= '0;
            neg_q   <= value[WIDTH-1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          bin_q <= bin_q << 1;
          bcd_q <= bcd_step;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Slot timing and the glyph for the digit being shown next cycle.
  always_comb begin
    pre_d = pre_q + REFRESH_BITS'(1);
    idx_d = idx_q;
    if (&pre_q) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);

    msd = '0;
    for (int unsigned i = 1; i < DIGITS - 1; i++) begin
      if (disp_bcd_d[4*i +: 4] != 4'd0) msd = IW'(i);
    end

    glyph = GLYPH_BLANK;
    if (disp_ovf_d) begin
      glyph = GLYPH_DASH;
    end else if (BLANK_LEADING != 0) begin
      if (idx_d <= msd)                             glyph = digit_glyph(disp_bcd_d[4*idx_d +: 4]);
      else if (disp_neg_d && idx_d == msd + IW'(1)) glyph = GLYPH_DASH;
    end else begin
      if (idx_d == IW'(DIGITS - 1)) glyph = disp_neg_d ? GLYPH_DASH : GLYPH_BLANK;
      else                          glyph = digit_glyph(disp_bcd_d[4*idx_d +: 4]);
    end

    anode_n_d = '1;
    seg_n_d   = GLYPH_BLANK;
    if (pre_d != '0) begin
      anode_n_d = ~(DIGITS'(1) << idx_d);
      seg_n_d   = glyph;
    end
  end

  // Scan counters and registered pin drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q     <= '0;
      idx_q     <= '0;
      anode_n_q <= '1;
      seg_n_q   <= GLYPH_BLANK;
    end else begin
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      anode_n_q <= anode_n_d;
      seg_n_q   <= seg_n_d;
    end
  end

  assign busy     = busy_q;
  assign overflow = disp_ovf_q;
  assign anode_n  = anode_n_q;
  assign seg_n    = seg_n_q;

endmodule

// File: tb/tb_seven_segment_scan_n.sv
// Scoreboard bench for seven_segment_scan_n: three instances sharing clock,
// reset and load (8-bit blanking, 8-bit no blanking, 12-bit blanking).
module tb_seven_segment_scan_n;

  typedef logic [6:0] glyph_t;
  localparam glyph_t BLANK = 7'h7F;
  localparam glyph_t DASH  = 7'b0111111;
  localparam glyph_t DIGIT_GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                          7'b0000000, 7'b0010000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [7:0]  value8 = '0;
  logic [11:0] value12 = '0;

  logic       b0, b1, b2, o0, o1, o2;
  logic [3:0] an0, an1, an2;
  logic [6:0] sg0, sg1, sg2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seven_segment_scan_n #(.WIDTH(8), .DIGITS(4), .REFRESH_BITS(2), .BLANK_LEADING(1)) u_bl8 (
    .clk(clk), .rst(rst), .value(value8), .load(load), .busy(b0), .overflow(o0),
    .anode_n(an0), .seg_n(sg0));
  seven_segment_scan_n #(.WIDTH(8), .DIGITS(4), .REFRESH_BITS(2), .BLANK_LEADING(0)) u_nb8 (
    .clk(clk), .rst(rst), .value(value8), .load(load), .busy(b1), .overflow(o1),
    .anode_n(an1), .seg_n(sg1));
  seven_segment_scan_n #(.WIDTH(12), .DIGITS(4), .REFRESH_BITS(2), .BLANK_LEADING(1)) u_bl12 (
    .clk(clk), .rst(rst), .value(value12), .load(load), .busy(b2), .overflow(o2),
    .anode_n(an2), .seg_n(sg2));

  function automatic int width_of(input int k);
    return (k == 2) ? 12 : 8;
  endfunction

  function automatic bit blank_of(input int k);
    return (k == 1) ? 1'b0 : 1'b1;
  endfunction

  // Reference: expected {overflow, glyph3, glyph2, glyph1, glyph0} from the decimal value.
  function automatic logic [28:0] expect_disp(input int v, input bit bl);
    int mag, nd, p;
    logic [28:0] r;
    glyph_t g;
    mag = (v < 0) ? -v : v;
    if (mag >= 1000) return {1'b1, DASH, DASH, DASH, DASH};
    nd = 1;
    p  = 10;
    while (p <= mag) begin
      nd++;
      p *= 10;
    end
    r = '0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      if (i < 3 && (!bl || i < nd))                 g = DIGIT_GLYPH[(mag / p) % 10];
      else if ((bl ? (i == nd) : (i == 3)) && v < 0) g = DASH;
      else                                          g = BLANK;
      r[7*i +: 7] = g;
      p *= 10;
    end
    return r;
  endfunction

  logic [28:0] q0[$], q1[$], q2[$];
  int          mleft [3];
  int          pcnt;
  logic [28:0] cur [3];
  logic        pbusy [3];
  int          bcnt [3];

  task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  // Model of request acceptance and slot timing; pushes expectations on accepted loads.
  always @(posedge clk) begin
    if (rst) begin
      pcnt = 0;
      for (int k = 0; k < 3; k++) mleft[k] = 0;
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      pcnt++;
      for (int k = 0; k < 3; k++) begin
        if (mleft[k] == 0) begin
          if (load) begin
            mleft[k] = width_of(k) + 1;
            case (k)
              0:       q0.push_back(expect_disp(int'($signed(value8)), blank_of(k)));
              1:       q1.push_back(expect_disp(int'($signed(value8)), blank_of(k)));
              default: q2.push_back(expect_disp(int'($signed(value12)), blank_of(k)));
            endcase
          end
        end else begin
          mleft[k]--;
        end
      end
    end
  end

  task automatic check(input int k, input logic bsy, input logic ovf,
                       input logic [3:0] an, input logic [6:0] sg);
    logic [28:0] c;
    logic [3:0]  exp_an;
    logic [6:0]  exp_sg;
    int          slot, idx;
    bit          got;
    if (rst) begin
      cmp("reset_anode", k, 32'(an), 32'hF);
      cmp("reset_seg", k, 32'(sg), 32'h7F);
      cmp("reset_busy", k, 32'(bsy), 32'h0);
      cur[k]   = expect_disp(0, blank_of(k));
      pbusy[k] = 1'b0;
      bcnt[k]  = 0;
      return;
    end
    if (pbusy[k] && !bsy) begin
      cmp("busy_length", k, 32'(bcnt[k]), 32'(width_of(k) + 1));
      got = 1'b0;
      c   = '0;
      case (k)
        0:       if (q0.size() > 0) begin c = q0.pop_front(); got = 1'b1; end
        1:       if (q1.size() > 0) begin c = q1.pop_front(); got = 1'b1; end
        default: if (q2.size() > 0) begin c = q2.pop_front(); got = 1'b1; end
      endcase
      cmp("scoreboard_nonempty", k, 32'(got), 32'h1);
      if (got) cur[k] = c;
    end
    bcnt[k]  = bsy ? bcnt[k] + 1 : 0;
    pbusy[k] = bsy;
    cmp("busy", k, 32'(bsy), 32'(mleft[k] > 0));
    c = cur[k];
    cmp("overflow", k, 32'(ovf), 32'(c[28]));
    slot   = pcnt % 4;
    idx    = (pcnt / 4) % 4;
    exp_an = (slot == 0) ? 4'hF : ~(4'b0001 << idx);
    exp_sg = (slot == 0) ? BLANK : c[7*idx +: 7];
    cmp("anode_n", k, 32'(an), 32'(exp_an));
    cmp("seg_n", k, 32'(sg), 32'(exp_sg));
  endtask

  // Monitor: compares every instance on each falling edge.
  always @(negedge clk) begin
    check(0, b0, o0, an0, sg0);
    check(1, b1, o1, an1, sg1);
    check(2, b2, o2, an2, sg2);
  end

  task automatic do_load(input int v);
    @(negedge clk);
    #1;
    value12 = 12'(v);
    value8  = 8'(v);
    load    = 1'b1;
    @(negedge clk);
    #1;
    load    = 1'b0;
    value12 = 12'($urandom);
    value8  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(3);
    #1 rst = 1'b0;
    idle(34);

    do_load(-128); idle(40);
    do_load(-5);   idle(40);
    do_load(1000); idle(40);
    do_load(999);  idle(40);
    do_load(0);    idle(40);

    // Requests during conversion, including the commit-cycle edge of the 8-bit units.
    do_load(42);
    do_load(7);
    idle(5);
    do_load(7);
    idle(40);

    // Reset in the middle of a conversion.
    do_load(-77);
    idle(4);
    #1 rst = 1'b1;
    idle(2);
    #1 rst = 1'b0;
    idle(40);

    for (int n = 0; n < 40; n++) begin
      do_load(int'($urandom_range(0, 4095)) - 2048);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(0, 14)));
      else                           idle(int'($urandom_range(16, 40)));
    end
    idle(40);

    cmp("scoreboard_drained", 0, 32'(q0.size() + q1.size() + q2.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
